reset_seq_ctrl: RTL and testbench
=================================

# reset_seq_ctrl

- Reset sequencer for the SoC clock domain.
- Merges reset requests from power-on, software and watchdog, and stretches each reset to a fixed minimum width.
- Releases the peripheral/interconnect reset first and the core reset a fixed gap later.
- Sits beside the clock/reset generator; its active-low outputs drive the SoC and core reset trees.

## Interface
- `HOLD_CYCLES`, default 16: cycles both resets stay asserted; legal range ≥1.
- `GAP_CYCLES`, default 4: cycles between `soc_rstn_o` release and `core_rstn_o` release; legal range ≥1.
- `clk_i`  in  1  sole clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `test_mode_i`  in  1  DFT bypass.
- `sw_req_i`  in  1  software reset request, single-cycle pulse.
- `wdt_req_i`  in  1  watchdog reset request, level.
- `req_ack_o`  out  1  one-cycle pulse when a request starts a sequence from IDLE.
- `busy_o`  out  1  high while a sequence is in progress (state ≠ IDLE).
- `soc_rstn_o`  out  1  active-low SoC/peripheral reset.
- `core_rstn_o`  out  1  active-low core reset.
- `cause_o`  out  2  cause of the last sequence: 00 power-on, 01 software, 10 watchdog, 11 software+watchdog.

## Operation
- FSM states: ASSERT, REL_SOC, REL_CORE, IDLE.
- `rst_i`=1:
  - state=ASSERT, counter=0, `soc_rstn_o`=0, `core_rstn_o`=0, `req_ack_o`=0, `busy_o`=1, `cause_o`=00.
- ASSERT:
  - Both resets low; counter increments.
  - After HOLD_CYCLES cycles: state→REL_SOC, counter cleared.
- REL_SOC:
  - `soc_rstn_o`=1, `core_rstn_o`=0; counter increments.
  - After GAP_CYCLES cycles: state→REL_CORE.
- REL_CORE:
  - Both resets high for one cycle; state→IDLE.
  - REL_CORE is a settle cycle so `busy_o` deasserts one cycle after the core release.
- IDLE:
  - Both resets high, `busy_o`=0.
  - `sw_req_i` or `wdt_req_i` high: state→ASSERT, counter=0, `req_ack_o`=1 for one cycle, `cause_o` updated from the request bits sampled that cycle.
- Request during ASSERT or REL_SOC:
  - State→ASSERT, counter=0, so the full HOLD_CYCLES restarts.
  - New request bits are OR-ed into `cause_o`.
  - No `req_ack_o`.
- Request during REL_CORE: handled as in IDLE, including `req_ack_o`.
- `wdt_req_i` held high: the block stays in ASSERT indefinitely.
- Counter width: `$clog2(max(HOLD_CYCLES,GAP_CYCLES))+1`; no wrap is possible.
- `test_mode_i`=1:
  - `soc_rstn_o` = `core_rstn_o` = ~`rst_i`, combinational bypass.
  - The FSM keeps running; `busy_o`, `req_ack_o` and `cause_o` are unaffected.

## Timing
- All outputs are registered except in the `test_mode_i` bypass.
- Power-on:
  - `soc_rstn_o` stays low for exactly HOLD_CYCLES cycles after the last cycle `rst_i` is sampled high.
  - `core_rstn_o` rises exactly GAP_CYCLES cycles after `soc_rstn_o`.
- Request accepted at edge N, from IDLE or REL_CORE:
  - Both resets go low and `req_ack_o`=1 after edge N.
  - `soc_rstn_o` returns high HOLD_CYCLES cycles later.
  - `core_rstn_o` returns high HOLD_CYCLES+GAP_CYCLES cycles later.
- `busy_o` falls one cycle after `core_rstn_o` rises.
- `rst_i` asserted mid-sequence: immediate return to the ASSERT reset state at the next edge; `cause_o`=00.

## Configuration
- Macro `RST_SEQ_CAUSE_EN`.
- Defined: 2-bit cause register implemented as described.
- Undefined: no cause register; `cause_o` tied to 2'b00; all other behaviour identical.

## Test plan
- Power-on, HOLD=16, GAP=4: release `rst_i` at cycle 0 -> `soc_rstn_o` rises at cycle 16, `core_rstn_o` at 20, `busy_o` falls at 21, `cause_o`=00.
- IDLE, `sw_req_i` pulse at cycle 100 -> `req_ack_o` pulse and both resets low at 101, `soc_rstn_o` high at 117, `core_rstn_o` high at 121, `cause_o`=01.
- `wdt_req_i` high for 40 cycles from IDLE -> resets held low throughout; `soc_rstn_o` rises 16 cycles after the last cycle of the request; `cause_o`=10.
- `sw_req_i` in ASSERT at hold count 10, then `wdt_req_i` pulse in REL_SOC -> each restarts a full 16-cycle hold, one `req_ack_o` total, `cause_o`=11.
- `rst_i` pulsed during REL_SOC -> both resets low next cycle, full power-on timing restarts, `cause_o`=00.
- `test_mode_i`=1, toggle `rst_i` -> both rstn outputs equal ~`rst_i` in the same cycle; with `RST_SEQ_CAUSE_EN` undefined, `cause_o` stays 00 in every scenario.

Source files
------------

// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: merges power-on/software/watchdog requests, stretches and staggers releases.
// Optional cause register enabled by defining RST_SEQ_CAUSE_EN.
module reset_seq_ctrl #(
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned GAP_CYCLES  = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       test_mode_i,
   input  logic       sw_req_i,
   input  logic       wdt_req_i,
   output logic       req_ack_o,
   output logic       busy_o,
   output logic       soc_rstn_o,
   output logic       core_rstn_o,
   output logic [1:0] cause_o
);

   localparam int unsigned MaxCycles = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles) + 1;
   localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
   localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {StAssert, StRelSoc, StRelCore, StIdle} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            soc_rstn_q, soc_rstn_d;
   logic            core_rstn_q, core_rstn_d;
   logic            busy_q, busy_d;
   logic            ack_q, ack_d;
   logic            req;
   logic            new_seq;

   assign req = sw_req_i | wdt_req_i;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      new_seq = 1'b0;
      unique case (state_q)
         StAssert: begin
            if (req) begin
               cnt_d = '0;
            end else if (cnt_q == HoldLast) begin
               state_d = StRelSoc;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StRelSoc: begin
            if (req) begin
               state_d = StAssert;
               cnt_d   = '0;
            end else if (cnt_q == GapLast) begin
               state_d = StRelCore;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StRelCore, StIdle: begin
            // A request here starts a fresh, acknowledged sequence.
            if (req) begin
               state_d = StAssert;
               cnt_d   = '0;
               new_seq = 1'b1;
            end else begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StAssert;
            cnt_d   = '0;
         end
      endcase
      soc_rstn_d  = (state_d != StAssert);
      core_rstn_d = (state_d == StRelCore) || (state_d == StIdle);
      busy_d      = (state_d != StIdle);
      ack_d       = new_seq;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StAssert;
         cnt_q       <= '0;
         soc_rstn_q  <= 1'b0;
         core_rstn_q <= 1'b0;
         busy_q      <= 1'b1;
         ack_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         soc_rstn_q  <= soc_rstn_d;
         core_rstn_q <= core_rstn_d;
         busy_q      <= busy_d;
         ack_q       <= ack_d;
      end
   end

`ifdef RST_SEQ_CAUSE_EN
   logic [1:0] cause_q, cause_d;

   // Fresh sequences replace the cause; restarts accumulate into it.
   always_comb begin
      cause_d = cause_q;
      if (new_seq) begin
         cause_d = {wdt_req_i, sw_req_i};
      end else if (req) begin
         cause_d = cause_q | {wdt_req_i, sw_req_i};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cause_q <= 2'b00;
      end else begin
         cause_q <= cause_d;
      end
   end

   assign cause_o = cause_q;
`else
   assign cause_o = 2'b00;
`endif

   // DFT bypass follows rst_i directly; the FSM keeps running underneath.
   assign soc_rstn_o  = test_mode_i ? ~rst_i : soc_rstn_q;
   assign core_rstn_o = test_mode_i ? ~rst_i : core_rstn_q;
   assign busy_o      = busy_q;
   assign req_ack_o   = ack_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed bench for reset_seq_ctrl (HOLD=16, GAP=4); expected cause masked when
// RST_SEQ_CAUSE_EN is undefined.
module tb_reset_seq_ctrl;

`ifdef RST_SEQ_CAUSE_EN
   localparam bit CauseEn = 1'b1;
`else
   localparam bit CauseEn = 1'b0;
`endif

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       test_mode_i = 1'b0;
   logic       sw_req_i = 1'b0;
   logic       wdt_req_i = 1'b0;
   logic       req_ack_o;
   logic       busy_o;
   logic       soc_rstn_o;
   logic       core_rstn_o;
   logic [1:0] cause_o;

   int n_cmp = 0;
   int n_err = 0;

   reset_seq_ctrl #(
      .HOLD_CYCLES(16),
      .GAP_CYCLES (4)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .test_mode_i(test_mode_i),
      .sw_req_i   (sw_req_i),
      .wdt_req_i  (wdt_req_i),
      .req_ack_o  (req_ack_o),
      .busy_o     (busy_o),
      .soc_rstn_o (soc_rstn_o),
      .core_rstn_o(core_rstn_o),
      .cause_o    (cause_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic       rst, tm, sw, wdt;
      logic       soc, core, busy, ack;
      logic [1:0] cause;
   } vec_t;

   vec_t tbl[8];

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string name, input logic soc, input logic core, input logic busy,
                        input logic ack, input logic [1:0] cause);
      logic [1:0] c;
      c = CauseEn ? cause : 2'b00;
      n_cmp++;
      if ({soc_rstn_o, core_rstn_o, busy_o, req_ack_o, cause_o} !== {soc, core, busy, ack, c}) begin
         n_err++;
         $display("FAIL %s: got soc=%b core=%b busy=%b ack=%b cause=%b, want soc=%b core=%b busy=%b ack=%b cause=%b",
                  name, soc_rstn_o, core_rstn_o, busy_o, req_ack_o, cause_o,
                  soc, core, busy, ack, c);
      end
   endtask

   // Edges after the last ASSERT restart: soc up at 16, core at 20, busy down at 21.
   task automatic release_run(input string tag, input logic [1:0] cause);
      for (int i = 1; i <= 22; i++) begin
         tick();
         check($sformatf("%s[%0d]", tag, i), i >= 16, i >= 20, i < 21, 1'b0, cause);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00};
      tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00};
      tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01};

      // Power-on
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("reset[%0d]", i), 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
      end
      rst_i = 1'b0;
      release_run("poweron", 2'b00);

      // Software pulse from IDLE
      sw_req_i = 1'b1;
      tick();
      check("sw_accept", 1'b0, 1'b0, 1'b1, 1'b1, 2'b01);
      sw_req_i = 1'b0;
      release_run("sw_seq", 2'b01);

      // Watchdog level held for 40 cycles
      wdt_req_i = 1'b1;
      for (int j = 0; j < 40; j++) begin
         tick();
         check($sformatf("wdt_hold[%0d]", j), 1'b0, 1'b0, 1'b1, j == 0, 2'b10);
      end
      wdt_req_i = 1'b0;
      release_run("wdt_seq", 2'b10);

      // sw restart at hold count 10, then wdt restart in REL_SOC
      sw_req_i = 1'b1;
      tick();
      check("merge_accept", 1'b0, 1'b0, 1'b1, 1'b1, 2'b01);
      sw_req_i = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         check($sformatf("merge_hold[%0d]", i), 1'b0, 1'b0, 1'b1, 1'b0, 2'b01);
      end
      sw_req_i = 1'b1;
      tick();
      check("merge_sw_restart", 1'b0, 1'b0, 1'b1, 1'b0, 2'b01);
      sw_req_i = 1'b0;
      for (int i = 1; i <= 17; i++) begin
         tick();
         check($sformatf("merge_rehold[%0d]", i), i >= 16, 1'b0, 1'b1, 1'b0, 2'b01);
      end
      wdt_req_i = 1'b1;
      tick();
      check("merge_wdt_restart", 1'b0, 1'b0, 1'b1, 1'b0, 2'b11);
      wdt_req_i = 1'b0;
      release_run("merge_seq", 2'b11);

      // rst_i pulse during REL_SOC
      sw_req_i = 1'b1;
      tick();
      check("rst_mid_accept", 1'b0, 1'b0, 1'b1, 1'b1, 2'b01);
      sw_req_i = 1'b0;
      for (int i = 1; i <= 17; i++) begin
         tick();
         check($sformatf("rst_mid_pre[%0d]", i), i >= 16, 1'b0, 1'b1, 1'b0, 2'b01);
      end
      rst_i = 1'b1;
      tick();
      check("rst_mid_hit", 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
      rst_i = 1'b0;
      release_run("rst_mid_seq", 2'b00);

      // Request in REL_CORE: acknowledged, cause replaced
      wdt_req_i = 1'b1;
      tick();
      check("relcore_first", 1'b0, 1'b0, 1'b1, 1'b1, 2'b10);
      wdt_req_i = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         check($sformatf("relcore_pre[%0d]", i), i >= 16, i >= 20, 1'b1, 1'b0, 2'b10);
      end
      sw_req_i = 1'b1;
      tick();
      check("relcore_accept", 1'b0, 1'b0, 1'b1, 1'b1, 2'b01);
      sw_req_i = 1'b0;
      release_run("relcore_seq", 2'b01);

      // Table: test-mode bypass and interaction with the running FSM
      for (int v = 0; v < 8; v++) begin
         rst_i       = tbl[v].rst;
         test_mode_i = tbl[v].tm;
         sw_req_i    = tbl[v].sw;
         wdt_req_i   = tbl[v].wdt;
         #1;
         if (tbl[v].tm) begin
            n_cmp++;
            if ({soc_rstn_o, core_rstn_o} !== {~tbl[v].rst, ~tbl[v].rst}) begin
               n_err++;
               $display("FAIL bypass_comb[%0d]: got soc=%b core=%b, want %b", v, soc_rstn_o,
                        core_rstn_o, ~tbl[v].rst);
            end
         end
         tick();
         check($sformatf("table[%0d]", v), tbl[v].soc, tbl[v].core, tbl[v].busy, tbl[v].ack,
               tbl[v].cause);
      end
      sw_req_i = 1'b0;
      // Restart sampled at table[6]; table[7] was the first hold edge after it.
      for (int k = 1; k <= 21; k++) begin
         tick();
         check($sformatf("table_tail[%0d]", k), k >= 15, k >= 19, k < 20, 1'b0, 2'b01);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
